// File: rtl/rgbw_sout.sv
// rgbw_sout: FIFO GRB words to SK6812 RGBW serial stream; define RGBW_WHITE_EXTRACT_EN to move min(R,G,B) into W.
module rgbw_sout #(
    parameter int T0H    = 29,
    parameter int T1H    = 58,
    parameter int TBIT   = 115,
    parameter int TRESET = 7680
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_rd_data,
    output logic        fifo_rd_en,
    output logic        sout,
    output logic        busy,
    output logic [15:0] pix_count
);
    typedef enum logic [2:0] {IDLE, CONVERT, BIT_HIGH, BIT_LOW, LATCH} state_t;
    localparam logic [12:0] T0H_LAST = 13'(T0H - 1);
    localparam logic [12:0] T1H_LAST = 13'(T1H - 1);
    localparam logic [12:0] L0_LAST  = 13'(TBIT - T0H - 1);
    localparam logic [12:0] L1_LAST  = 13'(TBIT - T1H - 1);
    localparam logic [12:0] RST_LAST = 13'(TRESET - 1);
    state_t      state_q, state_d;
    logic [25:0] hold_q, hold_d;
    logic [31:0] shift_q, shift_d;
    logic [4:0]  bit_q, bit_d;
    logic [12:0] cnt_q, cnt_d;
    logic [15:0] pix_q, pix_d;
    logic        rd_en_q, rd_en_d;
    logic        sout_q, sout_d;
    logic [7:0]  g, r, b, w;
    logic [31:0] conv;
    logic [12:0] hi_last, lo_last;
    logic        unused_bits;
    assign unused_bits = ^fifo_rd_data[29:24];
    assign g = hold_q[23:16];
    assign r = hold_q[15:8];
    assign b = hold_q[7:0];
`ifdef RGBW_WHITE_EXTRACT_EN
    logic [7:0] min_gr;
    assign min_gr = (g < r) ? g : r;
    assign w      = (min_gr < b) ? min_gr : b;
`else
    assign w = 8'h00;
`endif
    // w never exceeds any channel, so these subtractions cannot wrap
    assign conv    = {g - w, r - w, b - w, w};
    assign hi_last = shift_q[31] ? T1H_LAST : T0H_LAST;
    assign lo_last = shift_q[31] ? L1_LAST : L0_LAST;
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q + 13'd1;
        pix_d   = pix_q;
        rd_en_d = 1'b0;
        case (state_q)
            IDLE: begin
                // the pop cycle dispatches on the held word; fifo_empty is not looked at
                if (rd_en_q) begin
                    cnt_d   = 13'd0;
                    state_d = !hold_q[25] ? IDLE : hold_q[24] ? LATCH : CONVERT;
                    pix_d   = (hold_q[25] && hold_q[24]) ? 16'd0 : pix_q;
                end else if (!fifo_empty) begin
                    hold_d  = {fifo_rd_data[31:30], fifo_rd_data[23:0]};
                    rd_en_d = 1'b1;
                end
            end
            CONVERT: begin
                shift_d = conv;
                bit_d   = 5'd31;
                cnt_d   = 13'd0;
                state_d = BIT_HIGH;
            end
            BIT_HIGH: begin
                if (cnt_q == hi_last) begin
                    cnt_d   = 13'd0;
                    state_d = BIT_LOW;
                end
            end
            BIT_LOW: begin
                if (cnt_q == lo_last) begin
                    cnt_d   = 13'd0;
                    state_d = (bit_q == 5'd0) ? IDLE : BIT_HIGH;
                    pix_d   = (bit_q == 5'd0) ? pix_q + 16'd1 : pix_q;
                    shift_d = (bit_q == 5'd0) ? shift_q : {shift_q[30:0], 1'b0};
                    bit_d   = (bit_q == 5'd0) ? bit_q : bit_q - 5'd1;
                end
            end
            LATCH: state_d = (cnt_q == RST_LAST) ? IDLE : LATCH;
            default: state_d = IDLE;
        endcase
        sout_d = (state_d == BIT_HIGH);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            pix_q   <= '0;
            rd_en_q <= 1'b0;
            sout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            pix_q   <= pix_d;
            rd_en_q <= rd_en_d;
            sout_q  <= sout_d;
        end
    end
    assign fifo_rd_en = rd_en_q;
    assign sout       = sout_q;
    assign busy       = (state_q != IDLE) || rd_en_q;
    assign pix_count  = pix_q;
endmodule

// File: tb/tb_rgbw_sout.sv
// tb_rgbw_sout: directed bench for rgbw_sout with a small first-word-fall-through FIFO model.
module tb_rgbw_sout;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty;
    logic [31:0] fifo_rd_data;
    logic        fifo_rd_en, sout, busy;
    logic [15:0] pix_count;
    logic [31:0] mem [0:15];
    logic [3:0]  wr_ptr = 4'd0;
    logic [3:0]  rd_ptr = 4'd0;
    int total = 0;
    int bad = 0;

    rgbw_sout dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en(fifo_rd_en), .sout(sout), .busy(busy), .pix_count(pix_count)
    );

    always #5 clk = ~clk;
    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign fifo_rd_data = mem[rd_ptr];
    always @(negedge clk) if (fifo_rd_en && !fifo_empty) rd_ptr <= rd_ptr + 4'd1;

`ifdef RGBW_WHITE_EXTRACT_EN
    localparam logic [31:0] EXP_PIX = 32'h0010_2010;
    localparam logic [31:0] EXP_A   = 32'hFF00_0000;
    localparam logic [31:0] EXP_B   = 32'h0022_4412;
    localparam logic [31:0] EXP_C   = 32'h0000_00FF;
`else
    localparam logic [31:0] EXP_PIX = 32'h1020_3000;
    localparam logic [31:0] EXP_A   = 32'hFF00_0000;
    localparam logic [31:0] EXP_B   = 32'h1234_5600;
    localparam logic [31:0] EXP_C   = 32'hFFFF_FF00;
`endif

    task automatic push(input logic [31:0] word);
        mem[wr_ptr] = word;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    task automatic wait_rise(input string name);
        int n;
        n = 0;
        while (!sout && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sout !== 1'b1) begin
            bad++;
            $display("FAIL %s rise: sout=%b after %0d cycles, required 1", name, sout, n);
        end
    endtask

    // entered on the first high cycle of bit 31; returns on the idle cycle after the frame
    task automatic get_frame(output logic [31:0] data, output int len, output int bad_bits);
        data = '0;
        len = 0;
        bad_bits = 0;
        for (int i = 31; i >= 0; i--) begin
            int h;
            int l;
            h = 0;
            l = 0;
            while (sout && h < 200) begin
                h++;
                @(negedge clk);
            end
            if (i > 0) begin
                while (!sout && l < 200) begin
                    l++;
                    @(negedge clk);
                end
            end else begin
                while (!sout && busy && l < 200) begin
                    l++;
                    @(negedge clk);
                end
            end
            data[i] = (h == 58);
            if (h != 29 && h != 58) bad_bits++;
            if (i > 0 && h + l != 115) bad_bits++;
            len += h + l;
        end
    endtask

    task automatic check_frame(input string name, input logic [31:0] exp);
        logic [31:0] d;
        int len, bb;
        get_frame(d, len, bb);
        total++;
        if (d !== exp) begin
            bad++;
            $display("FAIL %s data: got=%h required=%h", name, d, exp);
        end
        total++;
        if (len != 3680) begin
            bad++;
            $display("FAIL %s frame_len: got=%0d required=3680", name, len);
        end
        total++;
        if (bb != 0) begin
            bad++;
            $display("FAIL %s bit_timing: bad_bits=%0d required=0", name, bb);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({sout, fifo_rd_en, busy} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctl: sout/rd_en/busy=%b required=000", {sout, fifo_rd_en, busy});
        end
        total++;
        if (pix_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_pix: got=%0d required=0", pix_count);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_pixel();
        push(32'h8010_2030);
        @(negedge clk);
        total++;
        if ({fifo_rd_en, busy} !== 2'b11) begin
            bad++;
            $display("FAIL pixel_capture: rd_en/busy=%b required=11", {fifo_rd_en, busy});
        end
        @(negedge clk);
        total++;
        if ({fifo_rd_en, sout, busy} !== 3'b001) begin
            bad++;
            $display("FAIL pixel_convert: rd_en/sout/busy=%b required=001", {fifo_rd_en, sout, busy});
        end
        @(negedge clk);
        total++;
        if (sout !== 1'b1) begin
            bad++;
            $display("FAIL pixel_rise_e2: sout=%b required=1", sout);
        end
        check_frame("pixel", EXP_PIX);
        total++;
        if (pix_count !== 16'd1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL pixel_end: pix=%0d busy=%b required pix=1 busy=0", pix_count, busy);
        end
    endtask

    task automatic test_latch_and_invalid();
        int n, hi, pops;
        push(32'h8000_0000);
        push(32'hC000_0000);
        wait_rise("latch_px");
        check_frame("latch_px", 32'h0000_0000);
        total++;
        if (pix_count !== 16'd2) begin
            bad++;
            $display("FAIL latch_pre_pix: got=%0d required=2", pix_count);
        end
        @(negedge clk);
        total++;
        if ({fifo_rd_en, busy} !== 2'b11) begin
            bad++;
            $display("FAIL latch_pop: rd_en/busy=%b required=11", {fifo_rd_en, busy});
        end
        push(32'h00FF_FFFF);
        @(negedge clk);
        total++;
        if (pix_count !== 16'd0) begin
            bad++;
            $display("FAIL latch_pix_clear: got=%0d required=0", pix_count);
        end
        n = 0;
        hi = 0;
        pops = 0;
        while (busy && n < 10000) begin
            if (sout) hi++;
            if (fifo_rd_en) pops++;
            n++;
            @(negedge clk);
        end
        total++;
        if (n != 7680) begin
            bad++;
            $display("FAIL latch_len: busy cycles=%0d required=7680", n);
        end
        total++;
        if (hi != 0 || pops != 0) begin
            bad++;
            $display("FAIL latch_quiet: sout_high=%0d pops=%0d required 0 and 0", hi, pops);
        end
        @(negedge clk);
        total++;
        if ({fifo_rd_en, busy} !== 2'b11) begin
            bad++;
            $display("FAIL invalid_pop: rd_en/busy=%b required=11", {fifo_rd_en, busy});
        end
        @(negedge clk);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (sout || busy || fifo_rd_en) n++;
            @(negedge clk);
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL invalid_quiet: active cycles=%0d required=0", n);
        end
        total++;
        if (pix_count !== 16'd0) begin
            bad++;
            $display("FAIL invalid_pix: got=%0d required=0", pix_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [3];
        int g;
        exp[0] = EXP_A;
        exp[1] = EXP_B;
        exp[2] = EXP_C;
        push(32'h80FF_0000);
        push(32'h8012_3456);
        push(32'h80FF_FFFF);
        wait_rise("b2b");
        for (int k = 0; k < 3; k++) begin
            check_frame($sformatf("b2b%0d", k), exp[k]);
            if (k < 2) begin
                g = 0;
                while (!sout && g < 50) begin
                    g++;
                    @(negedge clk);
                end
                total++;
                if (g < 1 || g > 3) begin
                    bad++;
                    $display("FAIL b2b%0d gap: got=%0d required 1..3", k, g);
                end
            end
        end
        total++;
        if (pix_count !== 16'd3) begin
            bad++;
            $display("FAIL b2b_pix: got=%0d required=3", pix_count);
        end
    endtask

    task automatic test_rst_mid();
        push(32'h80FF_FFFF);
        push(32'h8012_3456);
        wait_rise("rstmid");
        repeat (19 * 115 + 10) @(negedge clk);
        total++;
        if (sout !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_in_bit12: sout=%b required=1", sout);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({sout, busy, fifo_rd_en} !== 3'b000 || pix_count !== 16'd0) begin
            bad++;
            $display("FAIL rstmid_clear: sout/busy/rd_en=%b pix=%0d required 000 and 0",
                     {sout, busy, fifo_rd_en}, pix_count);
        end
        wait_rise("rstmid_next");
        check_frame("rstmid_next", EXP_B);
        total++;
        if (pix_count !== 16'd1) begin
            bad++;
            $display("FAIL rstmid_pix: got=%0d required=1", pix_count);
        end
    endtask

    initial begin
        test_reset();
        test_pixel();
        test_latch_and_invalid();
        test_back_to_back();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
